cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter: RST_HOLD, 4, cycles that cpu_rst stays asserted after rst is released (minimum 1).
REQ-002 Parameter: DIV_W, 8, width of the clock-enable divisor.
REQ-003 Parameter: CNT_W, 16, width of the burst length.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: mode  in  2  run mode: 00 halt, 01 free-run, 10 single-step, 11 burst.
REQ-008 Port: div  in  DIV_W  enable divisor; one tick every div+1 cycles.
REQ-009 Port: step  in  1  single-cycle request for one CPU cycle (mode 10).
REQ-010 Port: go  in  1  single-cycle burst start (mode 11).
REQ-011 Port: burst_len  in  CNT_W  number of CPU cycles per burst, sampled on accepted go.
REQ-012 Port: cpu_rst  out  1  stretched reset to the CPU core.
REQ-013 Port: cpu_ce  out  1  registered one-cycle CPU advance enable.
REQ-014 Port: busy  out  1  high in RUN, STEP or BURST.
REQ-015 Port: cycle_cnt  out  32  count of cpu_ce pulses since cpu_rst fell.

Function
REQ-016 States SHALL be HOLD, IDLE, RUN, STEP and BURST.
REQ-017 HOLD: cpu_rst=1, cpu_ce=0, hold counter counts cycles with rst low; at the RST_HOLD-th such edge go to IDLE and drive cpu_rst=0.
REQ-018 Divider: div_cnt counts 0..div outside HOLD; tick=1 when div_cnt>=div, then div_cnt<=0; div=0 gives a tick every cycle; a div decrease below div_cnt SHALL tick on the next cycle.
REQ-019 cpu_ce SHALL be registered: cpu_ce<=tick & (state is RUN, STEP or BURST), one cycle of latency from the tick.
REQ-020 IDLE: mode 01 -> RUN; mode 10 with step -> STEP; mode 11 with go and burst_len!=0 -> BURST (remaining<=burst_len); go with burst_len=0 SHALL be ignored.
REQ-021 RUN: cpu_ce on every tick; mode!=01 -> IDLE on the next edge, with no further cpu_ce.
REQ-022 STEP: exactly one cpu_ce on the first tick, then IDLE.
REQ-023 BURST: on each tick, pulse cpu_ce and decrement remaining; on the tick with remaining=1, go to IDLE; exactly burst_len pulses total.
REQ-024 Leaving mode 10/11 while in STEP/BURST SHALL abort to IDLE at the next edge; an aborting edge that coincides with a tick SHALL produce no cpu_ce.
REQ-025 step or go asserted outside IDLE, or in a non-matching mode, SHALL be ignored (not queued).
REQ-026 Mode 00 SHALL never produce cpu_ce.
REQ-027 cycle_cnt SHALL hold 0 while cpu_rst=1, increment once per cpu_ce, and wrap 0xFFFFFFFF -> 0.
REQ-028 busy SHALL be registered from the state (1 in RUN/STEP/BURST, 0 otherwise).

Reset
REQ-029 rst sampled high SHALL, on that edge and regardless of state: state=HOLD, cpu_rst=1, cpu_ce=0, busy=0, cycle_cnt=0, div_cnt=0, remaining=0, hold counter=0.
REQ-030 rst asserted mid-burst or mid-run SHALL discard the operation; no cpu_ce after the edge that sampled rst.

Verification
REQ-031 RST_HOLD=4; rst high 3 cycles, then low -> cpu_rst=1 through the 4th low-rst edge, then 0; cpu_ce=0 and cycle_cnt=0 throughout.
REQ-032 mode=01, div=0 for 8 cycles, then div=2 for 30 cycles -> cpu_ce every cycle, then 1 in 3; cycle_cnt rises by 8 and then by 10.
REQ-033 mode=10, div=3; step pulse, then a second step while busy -> exactly one cpu_ce and busy back to 0; the second step is ignored.
REQ-034 mode=11, div=1, burst_len=5, go -> 5 cpu_ce pulses 2 cycles apart, then busy=0 and cycle_cnt+=5; burst_len=0 with go -> no pulses, busy stays 0.
REQ-035 burst_len=100, mode changed to 00 after the 3rd pulse -> no further cpu_ce, IDLE on the next edge; rst mid-burst -> cpu_rst=1, cycle_cnt=0 on the next edge.
REQ-036 cycle_cnt forced near wrap (run from 0xFFFFFFFE in free-run) -> sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: stretches the core reset, divides the system clock into
// advance ticks, and gates those ticks into a one-cycle cpu_ce according to
// the selected run mode (halt, free-run, single-step, counted burst).
module cpu_run_ctrl #(
   parameter int RST_HOLD = 4,
   parameter int DIV_W    = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic             step,
   input  logic             go,
   input  logic [CNT_W-1:0] burst_len,
   output logic             cpu_rst,
   output logic             cpu_ce,
   output logic             busy,
   output logic [31:0]      cycle_cnt
);

   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      IDLE  = 3'd1,
      RUN   = 3'd2,
      STEP  = 3'd3,
      BURST = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [HW-1:0]    hold_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic             tick;
   logic             ce_nxt;

   // The divider only runs once the core is out of reset; >= makes a shrinking
   // div that falls below the current count tick immediately.
   assign tick = (state != HOLD) && (div_cnt >= div);

   // Next-state and advance-enable decode; a mode change out of the active
   // mode aborts without issuing a pulse even when it lands on a tick.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      ce_nxt        = 1'b0;
      case (state)
         HOLD: begin
            if (hold_cnt == HW'(RST_HOLD - 1))
               state_nxt = IDLE;
         end
         IDLE: begin
            case (mode)
               MODE_RUN:   state_nxt = RUN;
               MODE_STEP:  if (step) state_nxt = STEP;
               MODE_BURST: begin
                  if (go && (burst_len != '0)) begin
                     state_nxt     = BURST;
                     remaining_nxt = burst_len;
                  end
               end
               default:    state_nxt = IDLE;
            endcase
         end
         RUN: begin
            if (mode != MODE_RUN)
               state_nxt = IDLE;
            else
               ce_nxt = tick;
         end
         STEP: begin
            if (mode != MODE_STEP) begin
               state_nxt = IDLE;
            end else if (tick) begin
               ce_nxt    = 1'b1;
               state_nxt = IDLE;
            end
         end
         BURST: begin
            if (mode != MODE_BURST) begin
               state_nxt     = IDLE;
               remaining_nxt = '0;
            end else if (tick) begin
               ce_nxt        = 1'b1;
               remaining_nxt = remaining - CNT_W'(1);
               if (remaining == CNT_W'(1))
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   // State register plus the registered outputs derived from it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HOLD;
         cpu_rst   <= 1'b1;
         cpu_ce    <= 1'b0;
         busy      <= 1'b0;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         cpu_rst   <= (state_nxt == HOLD);
         cpu_ce    <= ce_nxt;
         busy      <= (state_nxt == RUN) || (state_nxt == STEP) || (state_nxt == BURST);
         remaining <= remaining_nxt;
      end
   end

   // Reset-stretch counter: counts low-rst edges spent in HOLD.
   always_ff @(posedge clk) begin
      if (rst)
         hold_cnt <= '0;
      else if (state == HOLD)
         hold_cnt <= hold_cnt + HW'(1);
      else
         hold_cnt <= '0;
   end

   // Clock-enable divider: wraps to zero on every tick.
   always_ff @(posedge clk) begin
      if (rst || (state == HOLD) || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // Advance counter moves on the same edge that raises cpu_ce.
   always_ff @(posedge clk) begin
      if (rst)
         cycle_cnt <= '0;
      else
         cycle_cnt <= cycle_cnt + 32'(ce_nxt);
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset stretch, free-run with divider,
// single-step, bursts, aborts, ignored requests and cycle counter wrap.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [7:0]  div;
   logic        step;
   logic        go;
   logic [15:0] burst_len;
   logic        cpu_rst;
   logic        cpu_ce;
   logic        busy;
   logic [31:0] cycle_cnt;

   int tests  = 0;
   int failed = 0;

   cpu_run_ctrl #(.RST_HOLD(4), .DIV_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .div       (div),
      .step      (step),
      .go        (go),
      .burst_len (burst_len),
      .cpu_rst   (cpu_rst),
      .cpu_ce    (cpu_ce),
      .busy      (busy),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   // advance one rising edge; outputs are then sampled 1 time unit later
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; mode = 2'b00; div = 8'd0; step = 1'b0; go = 1'b0; burst_len = 16'd0;
      for (int i = 0; i < 3; i++) edge1();
      tests++;
      if (cpu_rst !== 1'b1 || cpu_ce !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 32'd0) begin
         failed++;
         $display("FAIL reset_state: cpu_rst=%b cpu_ce=%b busy=%b cycle_cnt=%0d, need 1 0 0 0",
                  cpu_rst, cpu_ce, busy, cycle_cnt);
      end
      rst = 1'b0;
      bad = 0;
      for (int i = 1; i <= 3; i++) begin
         edge1();
         if (cpu_rst !== 1'b1 || cpu_ce !== 1'b0 || cycle_cnt !== 32'd0) bad++;
      end
      tests++;
      if (bad != 0) begin
         failed++;
         $display("FAIL reset_hold: %0d of the first 3 low-rst edges released early or pulsed, need 0", bad);
      end
      edge1();
      tests++;
      if (cpu_rst !== 1'b0 || cpu_ce !== 1'b0 || cycle_cnt !== 32'd0) begin
         failed++;
         $display("FAIL reset_release: cpu_rst=%b cpu_ce=%b cycle_cnt=%0d after 4th edge, need 0 0 0",
                  cpu_rst, cpu_ce, cycle_cnt);
      end
   endtask

   task automatic test_free_run();
      int ones, bad;
      mode = 2'b01; div = 8'd0;
      edge1();
      tests++;
      if (busy !== 1'b1 || cpu_ce !== 1'b0) begin
         failed++;
         $display("FAIL run_enter: busy=%b cpu_ce=%b, need 1 0", busy, cpu_ce);
      end
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 8 || cycle_cnt !== 32'd8) begin
         failed++;
         $display("FAIL run_div0: pulses=%0d cycle_cnt=%0d, need 8 8", ones, cycle_cnt);
      end
      div = 8'd2;
      ones = 0; bad = 0;
      for (int k = 1; k <= 30; k++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
         if (cpu_ce !== ((k % 3) == 0)) bad++;
      end
      tests++;
      if (ones != 10 || bad != 0 || cycle_cnt !== 32'd18) begin
         failed++;
         $display("FAIL run_div2: pulses=%0d misplaced=%0d cycle_cnt=%0d, need 10 0 18", ones, bad, cycle_cnt);
      end
      mode = 2'b00; div = 8'd0;
      ones = 0;
      for (int i = 0; i < 6; i++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 0 || busy !== 1'b0 || cycle_cnt !== 32'd18) begin
         failed++;
         $display("FAIL halt_mode: pulses=%0d busy=%b cycle_cnt=%0d, need 0 0 18", ones, busy, cycle_cnt);
      end
   endtask

   task automatic test_single_step();
      int ones;
      mode = 2'b10; div = 8'd3;
      edge1(); edge1();
      step = 1'b1;
      edge1();
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL step_busy: busy=%b, need 1", busy);
      end
      ones = (cpu_ce === 1'b1) ? 1 : 0;
      edge1();
      if (cpu_ce === 1'b1) ones++;
      step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 1 || busy !== 1'b0 || cycle_cnt !== 32'd19) begin
         failed++;
         $display("FAIL step_once: pulses=%0d busy=%b cycle_cnt=%0d, need 1 0 19", ones, busy, cycle_cnt);
      end
   endtask

   task automatic test_burst();
      int ones, last, bad;
      mode = 2'b11; div = 8'd1; burst_len = 16'd5;
      edge1(); edge1();
      go = 1'b1;
      edge1();
      go = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL burst_busy: busy=%b, need 1", busy);
      end
      ones = 0; last = -1; bad = 0;
      for (int k = 0; k < 20; k++) begin
         edge1();
         if (cpu_ce === 1'b1) begin
            ones++;
            if (last >= 0 && (k - last) != 2) bad++;
            last = k;
         end
      end
      tests++;
      if (ones != 5 || bad != 0 || busy !== 1'b0 || cycle_cnt !== 32'd24) begin
         failed++;
         $display("FAIL burst_5: pulses=%0d bad_gaps=%0d busy=%b cycle_cnt=%0d, need 5 0 0 24",
                  ones, bad, busy, cycle_cnt);
      end
      burst_len = 16'd0;
      go = 1'b1;
      edge1();
      go = 1'b0;
      ones = 0; bad = 0;
      for (int k = 0; k < 6; k++) begin
         if (busy !== 1'b0) bad++;
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 0 || bad != 0 || cycle_cnt !== 32'd24) begin
         failed++;
         $display("FAIL burst_len0: pulses=%0d busy_cycles=%0d cycle_cnt=%0d, need 0 0 24", ones, bad, cycle_cnt);
      end
   endtask

   task automatic test_abort();
      int ones;
      bit reached;
      // every edge is a tick, so the aborting edge coincides with one
      mode = 2'b11; div = 8'd0; burst_len = 16'd100;
      go = 1'b1;
      edge1();
      go = 1'b0;
      ones = 0; reached = 1'b0;
      for (int k = 0; k < 40 && !reached; k++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
         if (ones == 3) reached = 1'b1;
      end
      mode = 2'b00;
      tests++;
      if (!reached) begin
         failed++;
         $display("FAIL abort_wait: saw %0d pulses within 40 cycles, need 3", ones);
      end
      edge1();
      tests++;
      if (cpu_ce !== 1'b0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL abort_edge: cpu_ce=%b busy=%b, need 0 0", cpu_ce, busy);
      end
      ones = 0;
      for (int k = 0; k < 10; k++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 0 || cycle_cnt !== 32'd27) begin
         failed++;
         $display("FAIL abort_after: pulses=%0d cycle_cnt=%0d, need 0 27", ones, cycle_cnt);
      end
      // reset in the middle of a burst
      mode = 2'b11;
      go = 1'b1;
      edge1();
      go = 1'b0;
      edge1(); edge1();
      rst = 1'b1;
      edge1();
      tests++;
      if (cpu_rst !== 1'b1 || cycle_cnt !== 32'd0 || cpu_ce !== 1'b0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL rst_mid_burst: cpu_rst=%b cycle_cnt=%0d cpu_ce=%b busy=%b, need 1 0 0 0",
                  cpu_rst, cycle_cnt, cpu_ce, busy);
      end
      rst = 1'b0;
      ones = 0;
      for (int k = 0; k < 4; k++) begin
         edge1();
         if (cpu_ce === 1'b1) ones++;
      end
      tests++;
      if (ones != 0 || cpu_rst !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 32'd0) begin
         failed++;
         $display("FAIL rst_recover: pulses=%0d cpu_rst=%b busy=%b cycle_cnt=%0d, need 0 0 0 0",
                  ones, cpu_rst, busy, cycle_cnt);
      end
   endtask

   task automatic test_ignored();
      int bad;
      bad = 0;
      div = 8'd0;
      mode = 2'b00; step = 1'b1; go = 1'b1; burst_len = 16'd4;
      edge1();
      if (busy !== 1'b0) bad++;
      mode = 2'b10; step = 1'b0; go = 1'b1;
      edge1();
      if (busy !== 1'b0) bad++;
      mode = 2'b11; step = 1'b1; go = 1'b0;
      edge1();
      if (busy !== 1'b0) bad++;
      step = 1'b0;
      mode = 2'b00;
      edge1(); edge1();
      if (busy !== 1'b0 || cpu_ce !== 1'b0) bad++;
      tests++;
      if (bad != 0 || cycle_cnt !== 32'd0) begin
         failed++;
         $display("FAIL ignored_req: %0d checks started work, cycle_cnt=%0d, need 0 0", bad, cycle_cnt);
      end
   endtask

   task automatic test_wrap();
      mode = 2'b00; div = 8'd0;
      edge1();
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_cnt;
      mode = 2'b01;
      edge1();
      tests++;
      if (cycle_cnt !== 32'hFFFF_FFFE) begin
         failed++;
         $display("FAIL wrap_start: cycle_cnt=%h, need fffffffe", cycle_cnt);
      end
      edge1();
      tests++;
      if (cycle_cnt !== 32'hFFFF_FFFF || cpu_ce !== 1'b1) begin
         failed++;
         $display("FAIL wrap_max: cycle_cnt=%h cpu_ce=%b, need ffffffff 1", cycle_cnt, cpu_ce);
      end
      edge1();
      tests++;
      if (cycle_cnt !== 32'h0000_0000 || cpu_ce !== 1'b1) begin
         failed++;
         $display("FAIL wrap_zero: cycle_cnt=%h cpu_ce=%b, need 00000000 1", cycle_cnt, cpu_ce);
      end
      mode = 2'b00;
      edge1();
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_single_step();
      test_burst();
      test_abort();
      test_ignored();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
